// File: rtl/decode_src_arbiter.sv
// rtl/decode_src_arbiter.sv - FE/MS decoder source arbiter with sequence lock, burst limit and output register
module decode_src_arbiter #(
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned MaxMsBurst = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic [DataWidth-1:0] fe_data_i,
  input  logic                 fe_valid_i,
  output logic                 fe_ready_o,
  input  logic [DataWidth-1:0] ms_data_i,
  input  logic                 ms_valid_i,
  input  logic                 ms_last_i,
  output logic                 ms_ready_o,
  output logic [DataWidth-1:0] dec_data_o,
  output logic                 dec_src_o,
  output logic                 dec_valid_o,
  input  logic                 dec_ready_i,
  output logic                 busy_o
);

  localparam logic [3:0] MaxBurst = 4'(MaxMsBurst);

  typedef enum logic {
    IDLE,
    MS_SEQ
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] burst_cnt, burst_cnt_d;
  logic       can_accept, burst_ok;
  logic       ms_hs, fe_hs;

  assign can_accept = !dec_valid_o || dec_ready_i;
  assign burst_ok   = burst_cnt < MaxBurst;

  always_comb begin
    fe_ready_o  = 1'b0;
    ms_ready_o  = 1'b0;
    state_d     = state_q;
    burst_cnt_d = burst_cnt;

    // Readies are held low while in reset so nothing is accepted before the first edge.
    if (rst_ni && !flush_i && can_accept) begin
      unique case (state_q)
        IDLE: begin
          ms_ready_o = !fe_valid_i || burst_ok;
          fe_ready_o = !ms_valid_i || !burst_ok;
        end
        MS_SEQ: ms_ready_o = 1'b1;
        default: ;
      endcase
    end

    ms_hs = ms_valid_i && ms_ready_o;
    fe_hs = fe_valid_i && fe_ready_o;

    if (flush_i) begin
      state_d = IDLE;
    end else if (ms_hs) begin
      state_d = ms_last_i ? IDLE : MS_SEQ;
    end

    if (flush_i || fe_hs) begin
      burst_cnt_d = '0;
    end else if (ms_hs && ms_last_i && fe_valid_i) begin
      if (burst_ok) burst_cnt_d = burst_cnt + 4'd1;
    end else if (state_q == IDLE && !fe_valid_i) begin
      burst_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      burst_cnt <= '0;
    end else begin
      state_q   <= state_d;
      burst_cnt <= burst_cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dec_valid_o <= 1'b0;
      dec_data_o  <= '0;
      dec_src_o   <= 1'b0;
    end else if (flush_i) begin
      dec_valid_o <= 1'b0;
    end else if (ms_hs) begin
      dec_valid_o <= 1'b1;
      dec_data_o  <= ms_data_i;
      dec_src_o   <= 1'b1;
    end else if (fe_hs) begin
      dec_valid_o <= 1'b1;
      dec_data_o  <= fe_data_i;
      dec_src_o   <= 1'b0;
    end else if (dec_ready_i) begin
      dec_valid_o <= 1'b0;
    end
  end

  assign busy_o = (state_q == MS_SEQ) || dec_valid_o;

endmodule

// File: tb/tb_decode_src_arbiter.sv
// tb/tb_decode_src_arbiter.sv - vector table, directed corner sequences and random model check
module tb_decode_src_arbiter;
  localparam int DW  = 64;
  localparam int MAX = 4;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          flush;
  logic [DW-1:0] fe_data, ms_data, dec_data;
  logic          fe_valid, fe_ready, ms_valid, ms_last, ms_ready;
  logic          dec_src, dec_valid, dec_ready, busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_src_arbiter #(.DataWidth(DW), .MaxMsBurst(MAX)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush),
    .fe_data_i(fe_data), .fe_valid_i(fe_valid), .fe_ready_o(fe_ready),
    .ms_data_i(ms_data), .ms_valid_i(ms_valid), .ms_last_i(ms_last), .ms_ready_o(ms_ready),
    .dec_data_o(dec_data), .dec_src_o(dec_src), .dec_valid_o(dec_valid),
    .dec_ready_i(dec_ready), .busy_o(busy)
  );

  typedef struct {
    logic          fe_v;
    logic [DW-1:0] fe_d;
    logic          ms_v;
    logic [DW-1:0] ms_d;
    logic          ms_l;
    logic          dr;
    logic          fl;
    logic          x_fe_r;
    logic          x_ms_r;
    logic          x_v;
    logic [DW-1:0] x_d;
    logic          x_src;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fv, input logic [DW-1:0] fd, input logic mv,
                       input logic [DW-1:0] md, input logic ml, input logic dr, input logic fl);
    fe_valid = fv; fe_data = fd; ms_valid = mv; ms_data = md;
    ms_last = ml; dec_ready = dr; flush = fl;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    drive(1, 64'h99, 1, 64'h98, 0, 1, 0);
    @(negedge clk);
    chk("rst_dec_valid", dec_valid, 0);
    chk("rst_dec_data", dec_data, 0);
    chk("rst_dec_src", dec_src, 0);
    chk("rst_fe_ready", fe_ready, 0);
    chk("rst_ms_ready", ms_ready, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 1, 0);
    rst_ni = 1'b1;
  endtask

  // Reference model state: open macro-op sequence, MS wins while FE waits, output slot
  bit          m_open;
  int          m_streak;
  bit          m_valid;
  logic [DW-1:0] m_data;
  bit          m_src;

  initial begin
    logic [DW-1:0] got[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] tmp;
    bit fe_pend, fe_took;
    int mi, cycles;

    drive(0, 0, 0, 0, 0, 0, 0);

    //          fe_v fe_d    ms_v ms_d    l  dr fl  feR msR v  data    src
    vt[0]  = '{1, 64'h10, 0, 64'h0,  0, 1, 0,  1, 1, 0, 64'h0,  0};
    vt[1]  = '{1, 64'h11, 0, 64'h0,  0, 1, 0,  1, 1, 1, 64'h10, 0};
    vt[2]  = '{1, 64'h12, 0, 64'h0,  0, 1, 0,  1, 1, 1, 64'h11, 0};
    vt[3]  = '{1, 64'h55, 1, 64'hA1, 0, 1, 0,  0, 1, 1, 64'h12, 0};
    vt[4]  = '{1, 64'h55, 1, 64'hB2, 0, 1, 0,  0, 1, 1, 64'hA1, 1};
    vt[5]  = '{1, 64'h55, 1, 64'hC3, 1, 1, 0,  0, 1, 1, 64'hB2, 1};
    vt[6]  = '{1, 64'h55, 0, 64'h0,  0, 1, 0,  1, 1, 1, 64'hC3, 1};
    vt[7]  = '{0, 64'h0,  0, 64'h0,  0, 1, 0,  1, 1, 1, 64'h55, 0};
    vt[8]  = '{1, 64'h20, 0, 64'h0,  0, 1, 0,  1, 1, 0, 64'h55, 0};
    vt[9]  = '{1, 64'h21, 0, 64'h0,  0, 0, 0,  0, 0, 1, 64'h20, 0};
    vt[10] = '{1, 64'h21, 0, 64'h0,  0, 0, 0,  0, 0, 1, 64'h20, 0};
    vt[11] = '{1, 64'h21, 0, 64'h0,  0, 0, 0,  0, 0, 1, 64'h20, 0};
    vt[12] = '{1, 64'h21, 0, 64'h0,  0, 1, 0,  1, 1, 1, 64'h20, 0};
    vt[13] = '{0, 64'h0,  0, 64'h0,  0, 1, 0,  1, 1, 1, 64'h21, 0};
    vt[14] = '{0, 64'h0,  0, 64'h0,  0, 1, 0,  1, 1, 0, 64'h21, 0};

    next_cycle();
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(vt[i].fe_v, vt[i].fe_d, vt[i].ms_v, vt[i].ms_d, vt[i].ms_l, vt[i].dr, vt[i].fl);
      @(negedge clk);
      chk($sformatf("vec%0d_fe_ready", i), fe_ready, vt[i].x_fe_r);
      chk($sformatf("vec%0d_ms_ready", i), ms_ready, vt[i].x_ms_r);
      chk($sformatf("vec%0d_dec_valid", i), dec_valid, vt[i].x_v);
      chk($sformatf("vec%0d_dec_data", i), dec_data, vt[i].x_d);
      chk($sformatf("vec%0d_dec_src", i), dec_src, vt[i].x_src);
      next_cycle();
    end

    // Starvation: five single-uop MS sequences against one waiting FE entry
    do_reset();
    fe_pend = 1; mi = 0; cycles = 0;
    while (got.size() < 6 && cycles < 30) begin
      drive(fe_pend, 64'h77, mi < 5, 64'hB0 + DW'(mi), 1, 1, 0);
      @(negedge clk);
      fe_took = fe_ready && fe_valid;
      if (ms_ready && ms_valid) mi++;
      if (fe_took) fe_pend = 0;
      next_cycle();
      if (dec_valid) got.push_back(dec_data);
      if (fe_took) chk("burst_cnt_after_fe", DW'(dut.burst_cnt), 0);
      cycles++;
    end
    exp_q = '{64'hB0, 64'hB1, 64'hB2, 64'hB3, 64'h77, 64'hB4};
    chk("starve_count", DW'(got.size()), 6);
    for (int i = 0; i < 6 && i < got.size(); i++) chk($sformatf("starve_seq%0d", i), got[i], exp_q[i]);

    // Flush in the middle of a three-uop sequence
    do_reset();
    drive(1, 64'h66, 1, 64'hA1, 0, 1, 0);
    @(negedge clk); chk("fl_ms_ready_a", ms_ready, 1); next_cycle();
    drive(1, 64'h66, 1, 64'hB2, 0, 1, 0);
    @(negedge clk); chk("fl_fe_ready_seq", fe_ready, 0); chk("fl_ms_ready_b", ms_ready, 1); next_cycle();
    drive(1, 64'h66, 1, 64'hC3, 1, 1, 1);
    @(negedge clk); chk("fl_ms_ready_flush", ms_ready, 0); chk("fl_fe_ready_flush", fe_ready, 0); next_cycle();
    chk("fl_dec_valid", dec_valid, 0);
    drive(1, 64'h66, 0, 64'h0, 0, 1, 0);
    @(negedge clk); chk("fl_fe_ready_after", fe_ready, 1); chk("fl_busy_after", busy, 0); next_cycle();
    chk("fl_dec_valid_fe", dec_valid, 1); chk("fl_dec_data_fe", dec_data, 64'h66); chk("fl_dec_src_fe", dec_src, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    next_cycle();

    // Asynchronous reset mid-sequence, then a plain FE stream
    do_reset();
    drive(0, 0, 1, 64'hA1, 0, 1, 0);
    next_cycle();
    drive(1, 64'h10, 1, 64'hB2, 0, 1, 0);
    chk("ar_busy_before", busy, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("ar_dec_valid", dec_valid, 0); chk("ar_dec_data", dec_data, 0); chk("ar_dec_src", dec_src, 0);
    chk("ar_busy", busy, 0); chk("ar_fe_ready", fe_ready, 0); chk("ar_ms_ready", ms_ready, 0);
    next_cycle();
    rst_ni = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1, 64'h10 + DW'(k), 0, 0, 0, 1, 0);
      @(negedge clk); chk($sformatf("ar_fe_ready%0d", k), fe_ready, 1);
      next_cycle();
      chk($sformatf("ar_valid%0d", k), dec_valid, 1);
      chk($sformatf("ar_data%0d", k), dec_data, 64'h10 + DW'(k));
      chk($sformatf("ar_src%0d", k), dec_src, 0);
    end

    // Random traffic against the reference model
    do_reset();
    m_open = 0; m_streak = 0; m_valid = 0; m_data = '0; m_src = 0;
    for (int c = 0; c < 600; c++) begin
      bit fv, mv, ml, dr, fl, accept, ms_turn, x_ms_r, x_fe_r, ms_go, fe_go, was_open;
      fv = $urandom_range(0, 99) < 85;
      mv = $urandom_range(0, 99) < 55;
      ml = $urandom_range(0, 99) < 45;
      dr = $urandom_range(0, 99) < 75;
      fl = $urandom_range(0, 99) < 3;
      tmp = {$urandom, $urandom};
      drive(fv, tmp, mv, {$urandom, $urandom}, ml, dr, fl);
      @(negedge clk);
      accept = (!m_valid || dr) && !fl;
      // MS keeps its turn unless FE is waiting and MS has already had its fill
      ms_turn = !(fv && m_streak >= MAX);
      x_ms_r = accept && (m_open || ms_turn);
      x_fe_r = accept && !m_open && (!mv || m_streak >= MAX);
      chk("rnd_ms_ready", ms_ready, x_ms_r);
      chk("rnd_fe_ready", fe_ready, x_fe_r);
      chk("rnd_dec_valid", dec_valid, m_valid);
      if (m_valid) begin
        chk("rnd_dec_data", dec_data, m_data);
        chk("rnd_dec_src", dec_src, m_src);
      end
      chk("rnd_busy", busy, m_open || m_valid);
      ms_go = x_ms_r && mv;
      fe_go = x_fe_r && fv;
      was_open = m_open;
      if (fl) begin
        m_valid = 0; m_open = 0; m_streak = 0;
      end else begin
        if (ms_go) begin
          m_valid = 1; m_data = ms_data; m_src = 1; m_open = !ml;
        end else if (fe_go) begin
          m_valid = 1; m_data = fe_data; m_src = 0;
        end else if (dr) begin
          m_valid = 0;
        end
        if (fe_go || (!was_open && !fv)) m_streak = 0;
        else if (ms_go && ml && fv && m_streak < MAX) m_streak++;
      end
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
